fetch_sequencer: RTL

- Program-counter controller for the 256x8 instruction ROM; owns the ROM address bus.
- Streams fetched bytes to decode over a valid/ready handshake, one instruction per clock at full throughput.
- Supports branch redirect and back-pressure, and stops on a halt opcode when the optional feature is enabled.
- Sits between the instruction ROM and the decode stage of the NanoRisc core.

---
 rtl/nanorisc_pkg.sv | 18 +
 rtl/fetch_pc_next.sv | 27 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/nanorisc_pkg.sv
// Shared NanoRisc types and constants used by the fetch path.
package nanorisc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select for the fetch path: reset, redirect, increment or hold.
module fetch_pc_next
  import nanorisc_pkg::*;
#(
  parameter int                ADDR_W   = nanorisc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              reset,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  // Increment wraps naturally at ADDR_W bits.
  always_comb begin
    pc_next = pc;
    if (reset)
      pc_next = RESET_PC;
    else if (branch_valid)
      pc_next = branch_target;
    else if (advance)
      pc_next = pc + 1'b1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller for the instruction ROM, streaming bytes to decode.
// Halt-opcode detection is compiled in with FETCH_HALT_DETECT_EN.
//
// state | meaning
// IDLE  | reset or enable low; no capture
// FETCH | capturing one instruction per clock when the output slot frees
// HALT  | halt opcode captured; waits for a branch
module fetch_sequencer #(
  parameter int                 ADDR_W      = nanorisc_pkg::ADDR_W,
  parameter int                 INSTR_W     = nanorisc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = nanorisc_pkg::HALT_OPCODE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  import nanorisc_pkg::*;

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              capture;
  logic              halt_hit;

  // A redirect always wins over a capture in the same cycle.
  assign capture = (state == FETCH) && enable && (!instr_valid || instr_ready) && !branch_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = capture && (mem_data == HALT_OPCODE);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halt_hit = 1'b0;
`endif

  fetch_pc_next #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .reset         (reset),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .advance       (capture),
    .pc            (pc),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = FETCH;
      FETCH:   if (!enable) next_state = IDLE;
               else if (halt_hit) next_state = HALT;
      HALT:    if (branch_valid) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    halted = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halted = (state == HALT);
`endif
  end

  always_ff @(posedge clock) begin
    pc <= pc_next;
    if (reset) begin
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else if (branch_valid) begin
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr_valid <= 1'b1;
      instr_data  <= mem_data;
      instr_pc    <= pc;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  assign mem_address = pc;

endmodule
